// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_tx_dev_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIDX_W = 3;

  // Register offsets as decoded from Addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_TXEN  = 0;
  localparam int unsigned CTRL_IRQEN = 1;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the oldest entry.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// UART 8N1 transmitter with CPU register interface, TX FIFO and empty-FIFO interrupt.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd433
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] DIn,
  output logic [DATA_W-1:0] DOut,
  output logic              IRQ,
  output logic              txd
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        reg_sel;
  logic              wr_ctrl;
  logic              wr_data;
  logic              wr_div;
  logic [1:0]        ctrl_q;
  logic [DIV_W-1:0]  div_q;
  logic              ovf_q;
  logic              txen;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [BYTE_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [DIV_W-1:0]  bcnt_q;
  logic [DIV_W-1:0]  bcnt_d;
  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] shift_d;
  logic [BIDX_W-1:0] bidx_q;
  logic [BIDX_W-1:0] bidx_d;
  logic              txd_d;
  logic              unused_bits;

  assign reg_sel = Addr[3:2];
  assign wr_ctrl = WE && (reg_sel == REG_CTRL);
  assign wr_data = WE && (reg_sel == REG_DATA);
  assign wr_div  = WE && (reg_sel == REG_DIV);
  assign txen    = ctrl_q[CTRL_TXEN];

  assign unused_bits = ^{Addr[DATA_W-1:4], Addr[1:0], DIn[DATA_W-1:DIV_W]};

  uart_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (DIn[BYTE_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control/divisor registers and sticky overflow flag (cleared by any CTRL write)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      div_q  <= DIV_RESET;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= DIn[1:0];
        ovf_q  <= 1'b0;
      end else if (wr_data && fifo_full && !fifo_pop) begin
        ovf_q  <= 1'b1;
      end
      if (wr_div) div_q <= DIn[DIV_W-1:0];
    end
  end

  // Shift FSM state, baud counter, shifter and registered serial output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      bidx_q  <= '0;
      txd     <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      bidx_q  <= bidx_d;
      txd     <= txd_d;
    end
  end

  // Next-state logic; txd is derived from the next state so the line changes with the state
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    bidx_d   = bidx_q;
    fifo_pop = 1'b0;
    txd_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (txen && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bcnt_d   = div_q;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bcnt_q == '0) begin
          bcnt_d  = div_q;
          bidx_d  = '0;
          state_d = S_DATA;
        end else begin
          bcnt_d = bcnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bcnt_q == '0) begin
          bcnt_d  = div_q;
          shift_d = {1'b0, shift_q[BYTE_W-1:1]};
          if (bidx_q == BIDX_W'(BYTE_W - 1)) begin
            state_d = S_STOP;
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end else begin
          bcnt_d = bcnt_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bcnt_q == '0) begin
          if (txen && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            bcnt_d   = div_q;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Level interrupt: FIFO drained and transmitter idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= ctrl_q[CTRL_IRQEN] && fifo_empty && (state_q == S_IDLE);
    end
  end

  // Combinational register read mux
  always_comb begin
    DOut = '0;
    case (reg_sel)
      REG_CTRL: DOut[1:0] = ctrl_q;
      REG_STATUS: begin
        DOut[STAT_BUSY]                     = (state_q != S_IDLE);
        DOut[STAT_FULL]                     = fifo_full;
        DOut[STAT_EMPTY]                    = fifo_empty;
        DOut[STAT_OVF]                      = ovf_q;
        DOut[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
      end
      REG_DIV: DOut[DIV_W-1:0] = div_q;
      default: DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed/randomized bench for uart_tx_dev with a queue-based byte/frame reference model.
module tb_uart_tx_dev;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DATA   = 2'd2;
  localparam logic [1:0] A_DIV    = 2'd3;
  localparam int         DEPTH    = 8;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [31:0] Addr;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;
  logic        txd;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  uart_tx_dev dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .Addr  (Addr),
    .DIn   (DIn),
    .DOut  (DOut),
    .IRQ   (IRQ),
    .txd   (txd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input bit busy, input bit full, input bit empty,
                                              input bit ovf, input int cnt);
    return 32'(busy) + 32'(full) * 2 + 32'(empty) * 4 + 32'(ovf) * 8 + 32'(cnt) * 16;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    WE   = 1'b1;
    Addr = {28'h0, a, 2'b00};
    DIn  = d;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'h0, a, 2'b00};
    #1;
    d = DOut;
  endtask

  // Wait (bounded) for the first cycle of a start bit
  task automatic wait_start(output bit ok);
    int t;
    t = 0;
    while (txd !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ok = (txd === 1'b0);
    check("start_bit_seen", 32'(ok), 32'(1));
  endtask

  // Drain the expected-byte queue, checking every cycle of every bit back to back
  task automatic check_frames(input int div);
    bit         ok;
    bit         bad;
    logic [7:0] b;
    logic [9:0] bits;
    wait_start(ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    while (exp_q.size() > 0) begin
      b    = exp_q.pop_front();
      bits = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
        bad = 1'b0;
        for (int c = 0; c <= div; c++) begin
          if (txd !== bits[k]) bad = 1'b1;
          @(negedge clk);
        end
        check($sformatf("frame_%02h_bit%0d_wrong_cycles", b, k), 32'(bad), 32'(0));
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int          n;
    int          dv;
    bit          ok;
    bit          bad;
    bit          ovf_m;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    WE       = 1'b0;
    Addr     = '0;
    DIn      = '0;
    tick(2);

    // 1: reset values, visible while reset is still held and after release
    rd(A_STATUS, r); check("reset_status_during", r, 32'h4);
    reset = 1'b0;
    tick(1);
    check("reset_txd", 32'(txd), 32'(1));
    check("reset_irq", 32'(IRQ), 32'(0));
    rd(A_STATUS, r); check("reset_status", r, 32'h4);
    rd(A_DIV, r);    check("reset_div", r, 32'd433);
    rd(A_CTRL, r);   check("reset_ctrl", r, 32'h0);

    // 2: DIV=3, single 0xA5 frame; upper DIV bits ignored, DATA reads 0
    wr(A_DIV, 32'hABCD_0003);
    rd(A_DIV, r);  check("div_readback", r, 32'd3);
    wr(A_CTRL, 32'h1);
    rd(A_CTRL, r); check("ctrl_readback", r, 32'h1);
    exp_q.push_back(8'hA5);
    wr(A_DATA, 32'h0000_00A5);
    rd(A_DATA, r); check("data_reads_zero", r, 32'h0);
    check_frames(3);
    rd(A_STATUS, r); check("a5_busy_cleared", r, status_word(0, 0, 1, 0, 0));

    // 3: DIV=1, three back-to-back frames preloaded with TXEN=0
    wr(A_CTRL, 32'h0);
    wr(A_DIV, 32'd1);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'h00); wr(A_DATA, 32'h00);
    exp_q.push_back(8'hFF); wr(A_DATA, 32'hFF);
    exp_q.push_back(8'h55); wr(A_DATA, 32'h55);
    rd(A_STATUS, r); check("three_queued", r, status_word(0, 0, 0, 0, 3));
    wr(A_CTRL, 32'h1);
    check_frames(1);
    rd(A_STATUS, r); check("three_done", r, status_word(0, 0, 1, 0, 0));
    wr(A_CTRL, 32'h0);

    // 3b: randomized divisors and byte bursts
    for (int rnd = 0; rnd < 4; rnd++) begin
      dv = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, DEPTH));
      wr(A_DIV, 32'(dv));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        wr(A_DATA, {24'h0, b});
      end
      rd(A_STATUS, r); check($sformatf("rnd%0d_queued", rnd), r, status_word(0, n == DEPTH, 0, 0, n));
      wr(A_CTRL, 32'h1);
      check_frames(dv);
      rd(A_STATUS, r); check($sformatf("rnd%0d_done", rnd), r, status_word(0, 0, 1, 0, 0));
      wr(A_CTRL, 32'h0);
    end

    // 4: overflow with TXEN=0; 9th byte dropped
    wr(A_DIV, 32'd1);
    ovf_m = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else ovf_m = 1'b1;
      wr(A_DATA, {24'h0, b});
    end
    rd(A_STATUS, r); check("ovf_full", r, status_word(0, 1, 0, ovf_m, exp_q.size()));
    wr(A_CTRL, 32'h0);
    rd(A_STATUS, r); check("ovf_cleared", r, status_word(0, 1, 0, 0, exp_q.size()));
    wr(A_CTRL, 32'h1);
    check_frames(1);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (txd !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    check("ninth_byte_not_sent", 32'(bad), 32'(0));
    rd(A_STATUS, r); check("ovf_drained", r, status_word(0, 0, 1, 0, 0));

    // 5: interrupt on empty+idle, cleared by a push, returns after the frame
    wr(A_DIV, 32'd2);
    wr(A_CTRL, 32'h3);
    tick(1);
    check("irq_set_empty", 32'(IRQ), 32'(1));
    b = 8'($urandom);
    exp_q.push_back(b);
    wr(A_DATA, {24'h0, b});
    tick(1);
    check("irq_cleared_by_push", 32'(IRQ), 32'(0));
    check_frames(2);
    tick(1);
    check("irq_set_after_frame", 32'(IRQ), 32'(1));

    // 6: async reset in the middle of the DATA state
    wr(A_DIV, 32'd3);
    wr(A_DATA, 32'h3C);
    wait_start(ok);
    tick(5);
    check("pre_reset_txd_low", 32'(txd), 32'(0));
    #2 reset = 1'b1;
    #1;
    check("reset_txd_immediate", 32'(txd), 32'(1));
    check("reset_irq_immediate", 32'(IRQ), 32'(0));
    rd(A_STATUS, r); check("reset_fifo_flushed", r, status_word(0, 0, 1, 0, 0));
    rd(A_DIV, r);    check("reset_div_restored", r, 32'd433);
    @(negedge clk);
    reset = 1'b0;
    wr(A_DIV, 32'd2);
    wr(A_CTRL, 32'h1);
    b = 8'($urandom);
    exp_q.push_back(b);
    wr(A_DATA, {24'h0, b});
    check_frames(2);
    rd(A_STATUS, r); check("post_reset_done", r, status_word(0, 0, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
